intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have the following ports; clock and reset come first:
- clk  in  1  — system clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- interrupt  in  1  — external interrupt request, may be a 1-cycle pulse.
- uart_irq  in  1  — UART receive interrupt request.
- timer_irq  in  1  — timer interrupt request.
- irq_en  in  3  — per-source enable, mie bits {timer,uart,ext} = [2:0].
- glob_ie  in  1  — mstatus.MIE.
- mtvec  in  32  — trap vector; [1:0]=01 selects vectored mode, otherwise direct.
- mepc_in  in  32  — current mepc CSR value.
- pc_ex  in  32  — PC of the instruction in execute.
- ex_valid  in  1  — execute stage holds a valid instruction.
- stall  in  1  — pipeline stalled this cycle.
- is_mret  in  1  — execute instruction is mret.
- flush  out  1  — kill fetch/decode contents.
- redirect  out  1  — load PC from redirect_pc.
- redirect_pc  out  32  — next PC.
- epc_we  out  1  — write epc_out to mepc.
- epc_out  out  32  — saved PC.
- cause_we  out  1  — write cause to mcause.
- cause  out  32  — mcause value.
- ie_clear  out  1  — MPIE<=MIE, MIE<=0.
- ie_restore  out  1  — MIE<=MPIE.
- irq_ack  out  3  — one-hot acknowledge of the taken source.

REQ-002 SHALL use one clock domain; reset is asynchronous and active-high.

Function
REQ-003 SHALL keep a 3-bit sticky pending register: bit set in any cycle its request is high; cleared only in the cycle after that source is acknowledged, unless the request is still high.
REQ-004 SHALL compute eligible = pending & irq_en & {3{glob_ie}} combinationally.
REQ-005 SHALL apply fixed priority ext > uart > timer, with cause values 0x8000000B, 0x80000010, 0x80000007 respectively.
REQ-006 SHALL implement states IDLE, WAIT, TRAP, FLUSH; boundary = ex_valid & ~stall.
REQ-007 IDLE: eligible≠0 -> WAIT; otherwise remain.
REQ-008 WAIT: eligible==0 -> IDLE (interrupt withdrawn, no trap); boundary & ~is_mret -> TRAP; else remain.
REQ-009 In IDLE or WAIT, boundary & is_mret SHALL assert redirect=1, redirect_pc=mepc_in, ie_restore=1 and flush=1 for one cycle; the state is unchanged; mret wins over a simultaneous interrupt.
REQ-010 TRAP (exactly one cycle) SHALL assert all of the following, using the highest-priority eligible source sampled in this cycle:
- epc_we=1, epc_out=pc_ex.
- cause_we=1, cause per REQ-005.
- ie_clear=1, flush=1, redirect=1.
- irq_ack = one-hot of the taken source.
REQ-011 TRAP redirect_pc SHALL be {mtvec[31:2],2'b00} in direct mode, or {mtvec[31:2],2'b00} + 4×(cause[4:0]) in vectored mode; the arithmetic is 32-bit and wraps modulo 2^32.
REQ-012 If eligible becomes 0 in the TRAP cycle, no outputs SHALL assert and the state returns to IDLE.
REQ-013 FLUSH (one cycle) SHALL assert flush=1 only; next state IDLE; pending requests are re-evaluated from IDLE, giving at least 2 cycles between back-to-back traps.
REQ-014 All single-cycle strobes SHALL be 0 outside the cycles defined above; redirect_pc, epc_out and cause SHALL be 0 when their strobe is low.
REQ-015 Outputs SHALL be registered-state-derived combinational; the trap takes effect with latency 1 cycle after the boundary is seen in WAIT.

Reset
REQ-016 Reset SHALL force state IDLE, pending=000 and all outputs to 0, asynchronously, including mid-TRAP or mid-FLUSH; no strobe may complete after reset asserts.
REQ-017 Requests present during reset SHALL NOT be latched; sampling starts on the first rising edge after reset deasserts.

Verification
REQ-018 1-cycle interrupt pulse, irq_en=001, glob_ie=1, ex_valid=1, stall=0, pc_ex=0x40, mtvec=0x100 -> WAIT then TRAP: epc_out=0x40, cause=0x8000000B, redirect_pc=0x100, irq_ack=001, then a FLUSH cycle.
REQ-019 uart_irq and timer_irq high together, irq_en=110, mtvec=0x101 (vectored) -> uart taken first with redirect_pc=0x140; timer taken no earlier than 2 cycles later with redirect_pc=0x11C.
REQ-020 Pending ext with stall=1 for 5 cycles -> stays in WAIT with no strobes; trap occurs the cycle after stall drops.
REQ-021 is_mret at boundary with ext pending, mepc_in=0x80 -> redirect_pc=0x80, ie_restore=1, no trap that cycle; trap on the next boundary.
REQ-022 glob_ie=0 with interrupt pulsed -> no trap; glob_ie later set -> trap taken (pending bit is sticky); reset asserted in WAIT -> pending=000, no trap afterwards.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt controller: sticky pending requests, fixed-priority selection, and a
// trap/mret sequencer that drives PC redirect, CSR write strobes and pipeline flush.
module intr_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        uart_irq,
    input  logic        timer_irq,
    input  logic [2:0]  irq_en,
    input  logic        glob_ie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    input  logic [31:0] pc_ex,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic        is_mret,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        cause_we,
    output logic [31:0] cause,
    output logic        ie_clear,
    output logic        ie_restore,
    output logic [2:0]  irq_ack
);

    localparam int unsigned NSRC = 3;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_UART  = 32'h8000_0010;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        TRAP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   take;
    logic [31:0]       take_cause;
    logic [31:0]       vec_base;
    logic [31:0]       trap_pc;
    logic              boundary;
    logic              mret_now;

    assign boundary = ex_valid & ~stall;
    assign mret_now = boundary & is_mret;
    assign eligible = pending_q & irq_en & {NSRC{glob_ie}};

    // A source stays pending until the cycle after its acknowledge, unless still requesting.
    assign pending_d = (pending_q & ~irq_ack) | {timer_irq, uart_irq, interrupt};

    // Fixed priority: ext > uart > timer.
    always_comb begin
        take       = '0;
        take_cause = '0;
        if (eligible[0]) begin
            take       = 3'b001;
            take_cause = CAUSE_EXT;
        end else if (eligible[1]) begin
            take       = 3'b010;
            take_cause = CAUSE_UART;
        end else if (eligible[2]) begin
            take       = 3'b100;
            take_cause = CAUSE_TIMER;
        end
    end

    assign vec_base = {mtvec[31:2], 2'b00};
    assign trap_pc  = (mtvec[1:0] == 2'b01)
                    ? vec_base + {25'd0, take_cause[4:0], 2'b00}
                    : vec_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next state and strobes; everything is held low while reset is asserted.
    always_comb begin
        state_d     = state_q;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        epc_we      = 1'b0;
        epc_out     = '0;
        cause_we    = 1'b0;
        cause       = '0;
        ie_clear    = 1'b0;
        ie_restore  = 1'b0;
        irq_ack     = '0;
        if (!reset) begin
            case (state_q)
                IDLE, WAIT: begin
                    if (mret_now) begin
                        redirect    = 1'b1;
                        redirect_pc = mepc_in;
                        ie_restore  = 1'b1;
                        flush       = 1'b1;
                    end else if (state_q == IDLE) begin
                        if (|eligible) state_d = WAIT;
                    end else if (eligible == '0) begin
                        state_d = IDLE;
                    end else if (boundary) begin
                        state_d = TRAP;
                    end
                end
                TRAP: begin
                    if (|eligible) begin
                        epc_we      = 1'b1;
                        epc_out     = pc_ex;
                        cause_we    = 1'b1;
                        cause       = take_cause;
                        ie_clear    = 1'b1;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = trap_pc;
                        irq_ack     = take;
                        state_d     = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FLUSH: begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: per-cycle vector table with expected outputs queued and
// popped at the sample point, plus async-reset-mid-strobe sequences.
module tb_intr_ctrl;

    localparam int EXT  = 0;
    localparam int UART = 1;
    localparam int TMR  = 2;

    typedef struct packed {
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic        epc_we;
        logic [31:0] epc;
        logic        cause_we;
        logic [31:0] cause;
        logic        ie_clear;
        logic        ie_restore;
        logic [2:0]  ack;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  req;
        logic        gie, exv, stl, mret, rst;
        logic [2:0]  en;
        logic [31:0] mtvec, mepc, pc;
        exp_t        e;
    } vec_t;

    localparam exp_t EN = '0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0, uart_irq = 1'b0, timer_irq = 1'b0;
    logic [2:0]  irq_en = '0;
    logic        glob_ie = 1'b0;
    logic [31:0] mtvec = '0, mepc_in = '0, pc_ex = '0;
    logic        ex_valid = 1'b0, stall = 1'b0, is_mret = 1'b0;
    logic        flush, redirect, epc_we, cause_we, ie_clear, ie_restore;
    logic [31:0] redirect_pc, epc_out, cause;
    logic [2:0]  irq_ack;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    exp_t sb[$];
    string cur_name = "init";
    logic [2:0]  c_en = '0;
    logic [31:0] c_mtvec = '0, c_mepc = '0, c_pc = '0;

    intr_ctrl dut (
        .clk(clk), .reset(reset), .interrupt(interrupt), .uart_irq(uart_irq),
        .timer_irq(timer_irq), .irq_en(irq_en), .glob_ie(glob_ie), .mtvec(mtvec),
        .mepc_in(mepc_in), .pc_ex(pc_ex), .ex_valid(ex_valid), .stall(stall),
        .is_mret(is_mret), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .epc_we(epc_we), .epc_out(epc_out), .cause_we(cause_we), .cause(cause),
        .ie_clear(ie_clear), .ie_restore(ie_restore), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic exp_t e_flush();
        exp_t e = '0;
        e.flush = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mret(logic [31:0] pc);
        exp_t e = '0;
        e.flush = 1'b1; e.redirect = 1'b1; e.rpc = pc; e.ie_restore = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_trap(int src, logic [31:0] rpc, logic [31:0] epc);
        exp_t e = '0;
        e.flush = 1'b1; e.redirect = 1'b1; e.rpc = rpc;
        e.epc_we = 1'b1; e.epc = epc; e.cause_we = 1'b1; e.ie_clear = 1'b1;
        e.ack = 3'(1 << src);
        case (src)
            EXT:     e.cause = 32'h8000_000B;
            UART:    e.cause = 32'h8000_0010;
            default: e.cause = 32'h8000_0007;
        endcase
        return e;
    endfunction

    task automatic cfg(string nm, logic [2:0] en, logic [31:0] tv, logic [31:0] mepc, logic [31:0] pc);
        cur_name = nm; c_en = en; c_mtvec = tv; c_mepc = mepc; c_pc = pc;
    endtask

    task automatic add(exp_t e, logic [2:0] req = 3'b000, logic gie = 1'b1, logic exv = 1'b1,
                       logic stl = 1'b0, logic mret = 1'b0, logic rst = 1'b0);
        vec_t v;
        v.name = cur_name; v.req = req; v.gie = gie; v.exv = exv; v.stl = stl;
        v.mret = mret; v.rst = rst; v.en = c_en; v.mtvec = c_mtvec; v.mepc = c_mepc;
        v.pc = c_pc; v.e = e;
        vecs.push_back(v);
    endtask

    function automatic exp_t sample();
        exp_t g;
        g.flush = flush; g.redirect = redirect; g.rpc = redirect_pc; g.epc_we = epc_we;
        g.epc = epc_out; g.cause_we = cause_we; g.cause = cause; g.ie_clear = ie_clear;
        g.ie_restore = ie_restore; g.ack = irq_ack;
        return g;
    endfunction

    task automatic check(string nm);
        exp_t g, x;
        g = sample();
        x = sb.pop_front();
        checks++;
        if (g !== x) begin
            failures++;
            $display("FAIL %s: got fl=%b rd=%b rpc=%h ew=%b epc=%h cw=%b cause=%h icl=%b irs=%b ack=%b want fl=%b rd=%b rpc=%h ew=%b epc=%h cw=%b cause=%h icl=%b irs=%b ack=%b",
                     nm, g.flush, g.redirect, g.rpc, g.epc_we, g.epc, g.cause_we, g.cause,
                     g.ie_clear, g.ie_restore, g.ack, x.flush, x.redirect, x.rpc, x.epc_we,
                     x.epc, x.cause_we, x.cause, x.ie_clear, x.ie_restore, x.ack);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, queue its expectation, sample before the rise.
    task automatic apply(vec_t v, int idx);
        @(negedge clk);
        reset = v.rst;
        {timer_irq, uart_irq, interrupt} = v.req;
        glob_ie = v.gie; ex_valid = v.exv; stall = v.stl; is_mret = v.mret;
        irq_en = v.en; mtvec = v.mtvec; mepc_in = v.mepc; pc_ex = v.pc;
        sb.push_back(v.e);
        #2;
        check($sformatf("%s[%0d]", v.name, idx));
    endtask

    task automatic run_table();
        int idx = 0;
        string last = "";
        foreach (vecs[i]) begin
            if (vecs[i].name != last) begin
                idx = 0;
                last = vecs[i].name;
            end
            apply(vecs[i], idx);
            idx++;
        end
        vecs.delete();
    endtask

    // Assert reset asynchronously mid-cycle during TRAP (at_flush=0) or FLUSH (at_flush=1).
    task automatic reset_mid(string nm, int at_flush);
        cfg(nm, 3'b011, 32'h0000_0100, 32'h0, 32'h0000_0050);
        add(EN, 3'b011); add(EN); add(EN);
        add(e_trap(EXT, 32'h100, 32'h50));
        if (at_flush != 0) add(e_flush());
        run_table();
        #1 reset = 1'b1;
        sb.push_back(EN);
        #1 check({nm, "_async"});
        add(EN, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) add(EN);
        run_table();
    endtask

    initial begin
        cfg("reset", 3'b000, 32'h0, 32'h0, 32'h0);
        add(EN, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        cfg("ext_pulse", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0040);
        add(EN, 3'b001); add(EN); add(EN);
        add(e_trap(EXT, 32'h100, 32'h40)); add(e_flush()); add(EN);

        cfg("uart_timer_vec", 3'b110, 32'h0000_0101, 32'h0, 32'h0000_0040);
        add(EN, 3'b110); add(EN, 3'b110); add(EN);
        add(e_trap(UART, 32'h140, 32'h40)); add(e_flush()); add(EN); add(EN);
        add(e_trap(TMR, 32'h11C, 32'h40)); add(e_flush()); add(EN);

        cfg("stall", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0200);
        add(EN, 3'b001, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) add(EN, 3'b000, 1'b1, 1'b1, 1'b1);
        add(EN);
        add(e_trap(EXT, 32'h100, 32'h200)); add(e_flush()); add(EN);

        cfg("mret", 3'b001, 32'h0000_0100, 32'h0000_0080, 32'h0000_0300);
        add(EN, 3'b001, 1'b1, 1'b0); add(EN, 3'b000, 1'b1, 1'b0);
        add(e_mret(32'h80), 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
        add(EN);
        add(e_trap(EXT, 32'h100, 32'h300)); add(e_flush()); add(EN);
        add(e_mret(32'h80), 3'b000, 1'b1, 1'b1, 1'b0, 1'b1); add(EN);

        cfg("gie_sticky", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0040);
        add(EN, 3'b001, 1'b0);
        for (int k = 0; k < 3; k++) add(EN, 3'b000, 1'b0);
        add(EN); add(EN);
        add(e_trap(EXT, 32'h100, 32'h40)); add(e_flush()); add(EN);

        cfg("reset_in_wait", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0040);
        add(EN, 3'b001); add(EN, 3'b000, 1'b1, 1'b0); add(EN, 3'b000, 1'b1, 1'b0);
        add(EN, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(EN); add(EN); add(EN);
        add(EN, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(EN); add(EN); add(EN); add(EN);

        cfg("withdraw", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0060);
        add(EN, 3'b001, 1'b1, 1'b0); add(EN, 3'b000, 1'b1, 1'b0);
        add(EN, 3'b000, 1'b0, 1'b0); add(EN, 3'b000, 1'b0, 1'b1);
        add(EN); add(EN);
        add(e_trap(EXT, 32'h100, 32'h60)); add(e_flush()); add(EN);

        cfg("trap_lost", 3'b001, 32'h0000_0100, 32'h0, 32'h0000_0064);
        add(EN, 3'b001); add(EN); add(EN);
        add(EN, 3'b000, 1'b0); add(EN, 3'b000, 1'b0);
        add(EN, 3'b000, 1'b1, 1'b0); add(EN);
        add(e_trap(EXT, 32'h100, 32'h64)); add(e_flush()); add(EN);

        cfg("priority", 3'b111, 32'h0000_0101, 32'h0, 32'h0000_0040);
        add(EN, 3'b111); add(EN); add(EN);
        add(e_trap(EXT, 32'h12C, 32'h40)); add(e_flush()); add(EN); add(EN);
        add(e_trap(UART, 32'h140, 32'h40)); add(e_flush()); add(EN); add(EN);
        add(e_trap(TMR, 32'h11C, 32'h40)); add(e_flush()); add(EN);

        cfg("vec_wrap", 3'b010, 32'hFFFF_FFFD, 32'h0, 32'h0000_0044);
        add(EN, 3'b010); add(EN); add(EN);
        add(e_trap(UART, 32'h0000_003C, 32'h44)); add(e_flush()); add(EN);

        cfg("direct_mode3", 3'b100, 32'h0000_0203, 32'h0, 32'h0000_0048);
        add(EN, 3'b100); add(EN); add(EN);
        add(e_trap(TMR, 32'h200, 32'h48)); add(e_flush()); add(EN);

        run_table();

        reset_mid("rst_mid_trap", 0);
        reset_mid("rst_mid_flush", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
